// File: rtl/altivec_pkg.sv
// Shared types and constants for the AltiVec issue queue: entry layout, FSM states, sizes.
package altivec_pkg;

   localparam int         DEPTH  = 4;
   localparam int         PTR_W  = 2;
   localparam int         OCC_W  = 3;
   localparam logic [7:0] WD_MAX = 8'd255;

   typedef struct packed {
      logic [7:0]   ins;
      logic [127:0] vra;
      logic [127:0] vrb;
      logic         rc;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/altivec_issue_fifo.sv
// Four-entry in-order op buffer with wrapping pointers and an occupancy count.
module altivec_issue_fifo
   import altivec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  entry_t           wr_entry,
   output entry_t           head,
   output logic [OCC_W-1:0] occupancy,
   output logic             full
);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (push) begin
         mem_d[wr_ptr_q] = wr_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy and pointers alone decide which slots are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head      = mem_q[rd_ptr_q];
   assign occupancy = occ_q;
   assign full      = (occ_q == OCC_W'(DEPTH));

endmodule

// File: rtl/altivec_issue_queue.sv
// Buffers AltiVec ops and issues them one at a time to altivec_dut, with a completion watchdog.
module altivec_issue_queue
   import altivec_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_ins,
   input  logic [127:0] in_vra,
   input  logic [127:0] in_vrb,
   input  logic         in_rc,
   output logic [7:0]   ins,
   output logic [127:0] vra,
   output logic [127:0] vrb,
   output logic         rc,
   output logic         ins_en,
   output logic         vra_en,
   output logic         vrb_en,
   input  logic         dut_busy,
   input  logic         vrt_en,
   output logic [2:0]   occupancy,
   output logic [15:0]  issued_cnt,
   output logic         timeout_err
);

   entry_t      in_entry;
   entry_t      head;
   logic        push;
   logic        pop;
   logic        fifo_full;

   state_t      state_q, state_d;
   entry_t      out_q, out_d;
   logic        strobe_q, strobe_d;
   logic [15:0] issued_cnt_q, issued_cnt_d;
   logic [7:0]  wd_q, wd_d;
   logic        timeout_q, timeout_d;

   assign in_entry = '{ins: in_ins, vra: in_vra, vrb: in_vrb, rc: in_rc};
   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;

   altivec_issue_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .wr_entry  (in_entry),
      .head      (head),
      .occupancy (occupancy),
      .full      (fifo_full)
   );

   always_comb begin
      state_d      = state_q;
      out_d        = out_q;
      strobe_d     = 1'b0;
      issued_cnt_d = issued_cnt_q;
      wd_d         = wd_q;
      timeout_d    = timeout_q;
      pop          = 1'b0;

      case (state_q)
         IDLE: begin
            // vrt_en is ignored here: nothing is outstanding
            if ((occupancy != '0) && !dut_busy) begin
               pop          = 1'b1;
               out_d        = head;
               strobe_d     = 1'b1;
               issued_cnt_d = issued_cnt_q + 16'd1;
               wd_d         = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            state_d = vrt_en ? IDLE : WAIT;
         end
         WAIT: begin
            if (vrt_en) begin
               state_d = IDLE;
            end else if (wd_q == WD_MAX - 8'd1) begin
               wd_d      = WD_MAX;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_q        <= '0;
         strobe_q     <= 1'b0;
         issued_cnt_q <= '0;
         wd_q         <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         strobe_q     <= strobe_d;
         issued_cnt_q <= issued_cnt_d;
         wd_q         <= wd_d;
         timeout_q    <= timeout_d;
      end
   end

   assign ins         = out_q.ins;
   assign vra         = out_q.vra;
   assign vrb         = out_q.vrb;
   assign rc          = out_q.rc;
   assign ins_en      = strobe_q;
   assign vra_en      = strobe_q;
   assign vrb_en      = strobe_q;
   assign issued_cnt  = issued_cnt_q;
   assign timeout_err = timeout_q;

endmodule
